// File: rtl/decoder_64b66b.sv
// ----------------------------------------------------------------------------
// decoder_64b66b
//
// Receive-side 64b/66b block decoder. It takes 66-bit blocks from the RX
// gearbox, acquires and monitors block lock from the 2-bit sync headers, and
// requests single-bit slips from the gearbox while hunting. Each payload is
// descrambled with the self-synchronous G(x) = 1 + x^39 + x^58 descrambler.
// While locked, {header, data} is forwarded to the PCS decode stage through
// one AXI-Stream output register.
//
// Ports
//   clk            in   1   clock
//   reset_n        in   1   asynchronous active-low reset
//   s_axis_tdata   in   66  [65:64] sync header, [63:0] scrambled payload
//                           (bit 0 is first on the line)
//   s_axis_tvalid  in   1   input block valid
//   s_axis_tready  out  1   input ready (output register empty or draining)
//   m_axis_tdata   out  64  descrambled payload
//   m_axis_ttype   out  2   sync header of the block (01 data, 10 control)
//   m_axis_tuser   out  1   1 = invalid header (00/11), data still forwarded
//   m_axis_tvalid  out  1   output valid
//   m_axis_tready  in   1   output ready
//   rx_slip        out  1   one-cycle pulse: gearbox shifts alignment by one bit
//   block_lock     out  1   block lock achieved
// ----------------------------------------------------------------------------
module decoder_64b66b #(
    parameter int LOCK_CNT  = 64,
    parameter int INVLD_MAX = 16,
    parameter int SLIP_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [65:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [63:0] m_axis_tdata,
    output logic [1:0]  m_axis_ttype,
    output logic        m_axis_tuser,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        rx_slip,
    output logic        block_lock
);

    localparam int SH_W = $clog2(LOCK_CNT + 1);
    localparam int IV_W = $clog2(INVLD_MAX + 1);
    localparam int WT_W = $clog2(SLIP_WAIT + 1);

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_SLIP   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Control state
    state_t            state_q,     state_d;
    logic [SH_W-1:0]   sh_cnt_q,    sh_cnt_d;
    logic [IV_W-1:0]   invld_cnt_q, invld_cnt_d;
    logic [WT_W-1:0]   wait_cnt_q,  wait_cnt_d;
    logic              block_lock_q, block_lock_d;
    logic              rx_slip_q,   rx_slip_d;
    logic [57:0]       hist_q,      hist_d;
    logic              out_valid_q, out_valid_d;

    // Output data register
    logic [63:0]       out_data_q,  out_data_d;
    logic [1:0]        out_type_q,  out_type_d;
    logic              out_user_q,  out_user_d;

    logic              accept;
    logic              hv;
    logic              forward;
    logic [SH_W-1:0]   sh_inc;
    logic [IV_W-1:0]   invld_inc;
    logic [121:0]      descr_x;
    logic [63:0]       descr;

    assign s_axis_tready = m_axis_tready | ~out_valid_q;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign hv            = s_axis_tdata[65] ^ s_axis_tdata[64];

    // Serial stream view: history holds the previous block's bits 6..63, so
    // out[i] = in[i] ^ in[i-39] ^ in[i-58] becomes three aligned slices.
    assign descr_x = {s_axis_tdata[63:0], hist_q};
    assign descr   = descr_x[121:58] ^ descr_x[82:19] ^ descr_x[63:0];

    assign sh_inc    = sh_cnt_q + SH_W'(1);
    assign invld_inc = hv ? invld_cnt_q : invld_cnt_q + IV_W'(1);

    always_comb begin
        // NOTE: every variable assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        sh_cnt_d     = sh_cnt_q;
        invld_cnt_d  = invld_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        block_lock_d = block_lock_q;
        rx_slip_d    = 1'b0;
        hist_d       = hist_q;
        out_valid_d  = out_valid_q & ~m_axis_tready;
        out_data_d   = out_data_q;
        out_type_d   = out_type_q;
        out_user_d   = out_user_q;
        forward      = 1'b0;

        if (accept) begin
            hist_d  = s_axis_tdata[63:6];
            // Forwarding decision uses the lock state before this block.
            forward = block_lock_q;

            unique case (state_q)
                ST_HUNT: begin
                    if (hv) begin
                        if (sh_inc == SH_W'(LOCK_CNT)) begin
                            block_lock_d = 1'b1;
                            sh_cnt_d     = '0;
                            invld_cnt_d  = '0;
                            state_d      = ST_LOCKED;
                        end else begin
                            sh_cnt_d = sh_inc;
                        end
                    end else begin
                        rx_slip_d   = 1'b1;
                        sh_cnt_d    = '0;
                        invld_cnt_d = '0;
                        wait_cnt_d  = WT_W'(SLIP_WAIT);
                        state_d     = ST_SLIP;
                    end
                end

                ST_SLIP: begin
                    // Gearbox settle time: headers are not evaluated here.
                    wait_cnt_d = wait_cnt_q - WT_W'(1);
                    if (wait_cnt_q == WT_W'(1)) begin
                        state_d = ST_HUNT;
                    end
                end

                ST_LOCKED: begin
                    // Lock loss takes priority over the window rollover.
                    if (invld_inc == IV_W'(INVLD_MAX)) begin
                        block_lock_d = 1'b0;
                        rx_slip_d    = 1'b1;
                        sh_cnt_d     = '0;
                        invld_cnt_d  = '0;
                        wait_cnt_d   = WT_W'(SLIP_WAIT);
                        state_d      = ST_SLIP;
                        forward      = 1'b0;
                    end else if (sh_inc == SH_W'(LOCK_CNT)) begin
                        sh_cnt_d    = '0;
                        invld_cnt_d = '0;
                    end else begin
                        sh_cnt_d    = sh_inc;
                        invld_cnt_d = invld_inc;
                    end
                end

                default: begin
                    state_d = ST_HUNT;
                end
            endcase

            if (forward) begin
                out_valid_d = 1'b1;
                out_data_d  = descr;
                out_type_d  = s_axis_tdata[65:64];
                out_user_d  = ~hv;
            end
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_HUNT;
            sh_cnt_q     <= '0;
            invld_cnt_q  <= '0;
            wait_cnt_q   <= '0;
            block_lock_q <= 1'b0;
            rx_slip_q    <= 1'b0;
            hist_q       <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_cnt_q     <= sh_cnt_d;
            invld_cnt_q  <= invld_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            block_lock_q <= block_lock_d;
            rx_slip_q    <= rx_slip_d;
            hist_q       <= hist_d;
            out_valid_q  <= out_valid_d;
        end
    end

    // NOTE: the payload register is qualified by out_valid_q, so it carries
    // no reset; a block held at reset time is simply discarded.
    always_ff @(posedge clk) begin
        out_data_q <= out_data_d;
        out_type_q <= out_type_d;
        out_user_q <= out_user_d;
    end

    assign m_axis_tdata  = out_data_q;
    assign m_axis_ttype  = out_type_q;
    assign m_axis_tuser  = out_user_q;
    assign m_axis_tvalid = out_valid_q;
    assign rx_slip       = rx_slip_q;
    assign block_lock    = block_lock_q;

endmodule
